// File: rtl/rca_bist.sv
// Built-in self-test for a ripple carry adder: sweeps every {c_in,a,b} vector,
// checks {c_out,sum} against a behavioural sum, reports error count and first failure.
module rca_bist #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [WIDTH-1:0]     a,
  output logic [WIDTH-1:0]     b,
  output logic                 c_in,
  input  logic [WIDTH-1:0]     sum,
  input  logic                 c_out,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH+1:0]   err_count,
  output logic [2*WIDTH:0]     fail_vec
);

  localparam int unsigned VW = 2 * WIDTH + 1;
  localparam int unsigned CW = 2 * WIDTH + 2;
  localparam int unsigned RW = WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t         state;
  logic [VW-1:0]  v;
  logic [RW-1:0]  expected_c;
  logic           mismatch_c;
  logic           last_c;

  // Vector register drives the adder directly; b is the fastest-moving field.
  assign {c_in, a, b} = v;

  assign expected_c = RW'(a) + RW'(b) + RW'(c_in);
  assign mismatch_c = (expected_c != {c_out, sum});
  assign last_c     = &v;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      v         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            v         <= '0;
            err_count <= '0;
            fail_vec  <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          state <= CHECK;
        end
        CHECK: begin
          // Vector count bounds err_count, so the increment cannot wrap.
          if (mismatch_c) begin
            err_count <= err_count + CW'(1);
            if (err_count == '0) begin
              fail_vec <= v;
            end
          end
          if (last_c) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch_c;
            state <= DONE;
          end else begin
            v     <= v + VW'(1);
            state <= SETTLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_bist.sv
// Directed bench for rca_bist: behavioural adder with injectable faults beside
// a WIDTH=4 and a WIDTH=2 instance.
module tb_rca_bist;

  logic clk = 1'b0;
  logic rst;
  logic start4, start2;

  logic [3:0] a4, b4, s4;
  logic       ci4, co4, busy4, done4, pass4;
  logic [9:0] err4;
  logic [8:0] fail4;
  logic [4:0] r4;

  logic [1:0] a2, b2, s2;
  logic       ci2, co2, busy2, done2, pass2;
  logic [5:0] err2;
  logic [4:0] fail2;
  logic [2:0] r2;

  // 0 golden, 1 c_out stuck 0, 2 sum[0] stuck 1, 3 c_out stuck 1
  int fault4, fault2;
  int n_vec, n_err;
  int edges, busy_cnt;

  always #5 clk = ~clk;

  rca_bist #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4),
    .a(a4), .b(b4), .c_in(ci4), .sum(s4), .c_out(co4),
    .busy(busy4), .done(done4), .pass(pass4),
    .err_count(err4), .fail_vec(fail4)
  );

  rca_bist #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2),
    .a(a2), .b(b2), .c_in(ci2), .sum(s2), .c_out(co2),
    .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .fail_vec(fail2)
  );

  always_comb begin
    r4  = 5'(a4) + 5'(b4) + 5'(ci4);
    s4  = r4[3:0];
    co4 = r4[4];
    if (fault4 == 1) co4 = 1'b0;
    if (fault4 == 2) s4[0] = 1'b1;
    if (fault4 == 3) co4 = 1'b1;
  end

  always_comb begin
    r2  = 3'(a2) + 3'(b2) + 3'(ci2);
    s2  = r2[1:0];
    co2 = r2[2];
    if (fault2 == 1) co2 = 1'b0;
    if (fault2 == 2) s2[0] = 1'b1;
    if (fault2 == 3) co2 = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Raise start for one edge (or leave it high when hold is set).
  task automatic kick(input bit sel2, input bit hold);
    if (sel2) start2 = 1'b1; else start4 = 1'b1;
    step();
    if (!hold) begin
      start2 = 1'b0;
      start4 = 1'b0;
    end
  endtask

  // Counts edges from the start edge until done, bounded.
  task automatic wait_done(input bit sel2, output int n_edges, output int n_busy);
    n_edges = 1;
    n_busy  = 0;
    while (!(sel2 ? done2 : done4) && n_edges < 3000) begin
      if (sel2 ? busy2 : busy4) n_busy++;
      step();
      n_edges++;
    end
    start2 = 1'b0;
    start4 = 1'b0;
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    fault4 = 0;
    fault2 = 0;
    start4 = 1'b0;
    start2 = 1'b0;
    rst    = 1'b1;
    step();
    step();

    check("rst_a",     32'(a4), 32'h0);
    check("rst_b",     32'(b4), 32'h0);
    check("rst_cin",   32'(ci4), 32'h0);
    check("rst_busy",  32'(busy4), 32'h0);
    check("rst_done",  32'(done4), 32'h0);
    check("rst_pass",  32'(pass4), 32'h0);
    check("rst_err",   32'(err4), 32'h0);
    check("rst_fail",  32'(fail4), 32'h0);
    check("rst_done2", 32'(done2), 32'h0);
    rst = 1'b0;
    step();

    // Golden sweep, WIDTH=4
    kick(1'b0, 1'b0);
    check("g_busy_first", 32'(busy4), 32'h1);
    check("g_vec_first",  32'({ci4, a4, b4}), 32'h0);
    wait_done(1'b0, edges, busy_cnt);
    check("g_done_edge", 32'(edges), 32'd1025);
    check("g_busy_cyc",  32'(busy_cnt), 32'd1024);
    check("g_busy_end",  32'(busy4), 32'h0);
    check("g_pass",      32'(pass4), 32'h1);
    check("g_err",       32'(err4), 32'h0);
    check("g_last_vec",  32'({ci4, a4, b4}), 32'h1FF);

    // c_out stuck at 0: 120 + 136 mismatches, first at c_in=0 a=1 b=15
    fault4 = 1;
    kick(1'b0, 1'b0);
    wait_done(1'b0, edges, busy_cnt);
    check("co0_edge", 32'(edges), 32'd1025);
    check("co0_err",  32'(err4), 32'd256);
    check("co0_fail", 32'(fail4), 32'h01F);
    check("co0_pass", 32'(pass4), 32'h0);
    check("co0_done", 32'(done4), 32'h1);
    step();
    check("co0_hold_err", 32'(err4), 32'd256);

    // Restart from DONE clears results
    fault4 = 0;
    kick(1'b0, 1'b0);
    check("rs_err",  32'(err4), 32'h0);
    check("rs_fail", 32'(fail4), 32'h0);
    check("rs_done", 32'(done4), 32'h0);
    check("rs_busy", 32'(busy4), 32'h1);
    check("rs_vec",  32'({ci4, a4, b4}), 32'h0);
    wait_done(1'b0, edges, busy_cnt);
    check("rs_pass", 32'(pass4), 32'h1);

    // sum[0] stuck at 1: every even true sum fails, first at v=0
    fault4 = 2;
    kick(1'b0, 1'b0);
    wait_done(1'b0, edges, busy_cnt);
    check("s0_err",  32'(err4), 32'd256);
    check("s0_fail", 32'(fail4), 32'h000);
    check("s0_pass", 32'(pass4), 32'h0);

    // Reset mid-sweep aborts to reset values
    fault4 = 0;
    kick(1'b0, 1'b0);
    for (int i = 0; i < 300; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_busy", 32'(busy4), 32'h0);
    check("mid_done", 32'(done4), 32'h0);
    check("mid_vec",  32'({ci4, a4, b4}), 32'h0);
    check("mid_err",  32'(err4), 32'h0);
    check("mid_fail", 32'(fail4), 32'h0);
    step();
    check("mid_idle", 32'(busy4), 32'h0);
    kick(1'b0, 1'b0);
    wait_done(1'b0, edges, busy_cnt);
    check("mid_edge", 32'(edges), 32'd1025);
    check("mid_pass", 32'(pass4), 32'h1);

    // start held high across the sweep must not restart it
    kick(1'b0, 1'b1);
    wait_done(1'b0, edges, busy_cnt);
    check("hold_edge", 32'(edges), 32'd1025);
    check("hold_busy", 32'(busy_cnt), 32'd1024);
    check("hold_pass", 32'(pass4), 32'h1);

    // rst wins over start
    rst    = 1'b1;
    start4 = 1'b1;
    step();
    rst    = 1'b0;
    start4 = 1'b0;
    check("rst_start_busy", 32'(busy4), 32'h0);
    check("rst_start_done", 32'(done4), 32'h0);

    // WIDTH=2 golden
    kick(1'b1, 1'b0);
    wait_done(1'b1, edges, busy_cnt);
    check("w2_edge", 32'(edges), 32'd65);
    check("w2_busy", 32'(busy_cnt), 32'd64);
    check("w2_pass", 32'(pass2), 32'h1);
    check("w2_err",  32'(err2), 32'h0);

    // WIDTH=2 c_out stuck at 1: fails whenever a+b+c_in < 4 (10 + 6 vectors)
    fault2 = 3;
    kick(1'b1, 1'b0);
    wait_done(1'b1, edges, busy_cnt);
    check("w2co1_err",  32'(err2), 32'd16);
    check("w2co1_fail", 32'(fail2), 32'h00);
    check("w2co1_pass", 32'(pass2), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
